// File: rtl/alu_pkg.sv
// Shared definitions for the condition-code ALU: operation encodings,
// condition-code bit positions and the reset value of the flags.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // Flags after reset describe an all-zero result.
   localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result is b <op> a, plus zero/sign/overflow
// flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam int MSB = WIDTH - 1;

   always_comb begin
      result = '0;
      of     = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: begin
            result = b + a;
            of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
         end
         ALU_SUB: begin
            // b - a overflows only when operand signs differ and the
            // result sign departs from the minuend b.
            result = b - a;
            of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
         end
         ALU_AND: result = b & a;
         ALU_XOR: result = b ^ a;
         default: result = '0;
      endcase
   end

   assign zf = (result == '0);
   assign sf = result[MSB];

endmodule

// File: rtl/alu_cc_unit.sv
// ALU with a one-entry registered output stage, valid/ready handshake on
// both sides, and condition codes updated only by operations with set_cc.
module alu_cc_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       cc
);

   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       cc_q, cc_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] core_result;
   logic             core_zf, core_sf, core_of;
   logic             xfer_in;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (op),
      .a      (a),
      .b      (b),
      .result (core_result),
      .zf     (core_zf),
      .sf     (core_sf),
      .of     (core_of)
   );

   // The output register can refill in the same cycle it is drained.
   assign in_ready = !out_valid_q || out_ready;
   assign xfer_in  = in_valid && in_ready;

   always_comb begin
      result_d    = result_q;
      cc_d        = cc_q;
      out_valid_d = out_valid_q;
      if (xfer_in) begin
         result_d    = core_result;
         out_valid_d = 1'b1;
         if (set_cc) begin
            cc_d[CC_ZF] = core_zf;
            cc_d[CC_SF] = core_sf;
            cc_d[CC_OF] = core_of;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         cc_q        <= CC_RESET;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         cc_q        <= cc_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cc        = cc_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Self-checking bench for alu_cc_unit at WIDTH=64 and WIDTH=8, driven against
// a signed-arithmetic reference model and an in-order result scoreboard.
module tb_alu_cc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iv   [2];
   logic        ordy [2];
   logic        sc_s [2];
   logic [1:0]  op_s [2];
   logic [63:0] a_s  [2];
   logic [63:0] b_s  [2];

   logic        ir64, ov64, ir8, ov8;
   logic [63:0] r64;
   logic [7:0]  r8;
   logic [2:0]  cc64, cc8;

   int checks = 0;
   int errors = 0;

   // Reference state per unit (0 = 64-bit, 1 = 8-bit)
   logic        m_valid [2];
   logic [63:0] m_res   [2];
   logic [2:0]  m_cc    [2];
   logic [63:0] exq0[$];
   logic [63:0] exq1[$];
   int          n_in  [2];
   int          n_out [2];

   always #5 clk = ~clk;

   alu_cc_unit #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir64), .op(op_s[0]),
      .a(a_s[0]), .b(b_s[0]), .set_cc(sc_s[0]), .out_valid(ov64),
      .out_ready(ordy[0]), .result(r64), .cc(cc64)
   );

   alu_cc_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .op(op_s[1]),
      .a(a_s[1][7:0]), .b(b_s[1][7:0]), .set_cc(sc_s[1]), .out_valid(ov8),
      .out_ready(ordy[1]), .result(r8), .cc(cc8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: signed arithmetic on sign-extended operands; overflow means
   // the exact sum/difference does not fit in w signed bits.
   function automatic logic [66:0] ref_op(input int w, input logic [1:0] o,
                                          input logic [63:0] av, input logic [63:0] bv);
      logic [63:0]        mask, am, bm, r;
      logic signed [65:0] sa, sb, s, smax, smin;
      logic               ofl;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      am   = av & mask;
      bm   = bv & mask;
      sa   = $signed({2'b00, am});
      sb   = $signed({2'b00, bm});
      if (am[w-1]) sa = sa - (66'sd1 <<< w);
      if (bm[w-1]) sb = sb - (66'sd1 <<< w);
      smax = (66'sd1 <<< (w - 1)) - 66'sd1;
      smin = 66'sd0 - (66'sd1 <<< (w - 1));
      case (o)
         2'd0:    s = sb + sa;
         2'd1:    s = sb - sa;
         2'd2:    s = $signed({2'b00, am & bm});
         default: s = $signed({2'b00, am ^ bm});
      endcase
      r   = s[63:0] & mask;
      ofl = (o < 2'd2) && ((s > smax) || (s < smin));
      return {(r == 64'd0), r[w-1], ofl, r};
   endfunction

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0080;
         3:       return 64'h7FFF_FFFF_FFFF_FF7F;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [63:0] obs_res(input int u);
      return (u == 1) ? {56'd0, r8} : r64;
   endfunction

   // One clock cycle on unit u; the other unit idles (no transfers).
   task automatic cyc(input int u, input logic v, input logic [1:0] o,
                      input logic [63:0] av, input logic [63:0] bv,
                      input logic sc, input logic rdy);
      logic [66:0] rf;
      logic        xin, xout;
      logic [63:0] exp_front;
      iv[u] = v; op_s[u] = o; a_s[u] = av; b_s[u] = bv; sc_s[u] = sc; ordy[u] = rdy;
      iv[1-u] = 1'b0; ordy[1-u] = 1'b0;
      #1;
      chk($sformatf("u%0d in_ready", u), (u == 1) ? ir8 : ir64, !m_valid[u] || rdy);
      xin  = v && (!m_valid[u] || rdy);
      xout = m_valid[u] && rdy;
      rf   = ref_op((u == 1) ? 8 : 64, o, av, bv);
      if (xout) begin
         exp_front = (u == 1) ? exq1.pop_front() : exq0.pop_front();
         chk($sformatf("u%0d deliver#%0d", u, n_out[u]), obs_res(u), exp_front);
         n_out[u]++;
      end
      @(posedge clk);
      #1;
      if (xin) begin
         m_valid[u] = 1'b1;
         m_res[u]   = rf[63:0];
         if (u == 1) exq1.push_back(rf[63:0]); else exq0.push_back(rf[63:0]);
         n_in[u]++;
         if (sc) m_cc[u] = rf[66:64];
      end else if (xout) begin
         m_valid[u] = 1'b0;
      end
      chk($sformatf("u%0d out_valid", u), (u == 1) ? ov8 : ov64, m_valid[u]);
      chk($sformatf("u%0d result", u), obs_res(u), m_res[u]);
      chk($sformatf("u%0d cc", u), (u == 1) ? cc8 : cc64, m_cc[u]);
      $display("u%0d v=%0b op=%0d a=%h b=%h sc=%0b rdy=%0b -> ov=%0b res=%h cc=%b",
               u, v, o, av, bv, sc, rdy, (u == 1) ? ov8 : ov64, obs_res(u),
               (u == 1) ? cc8 : cc64);
   endtask

   task automatic do_reset(input logic v, input logic rdy);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         iv[k] = v; ordy[k] = rdy; op_s[k] = 2'd0; a_s[k] = 64'd3; b_s[k] = 64'd4; sc_s[k] = 1'b1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0;
         m_valid[k] = 1'b0; m_res[k] = 64'd0; m_cc[k] = 3'b100;
      end
      exq0.delete();
      exq1.delete();
      #1;
      chk("rst ov64", ov64, 1'b0);
      chk("rst r64", r64, 64'd0);
      chk("rst cc64", cc64, 3'b100);
      chk("rst ir64", ir64, 1'b1);
      chk("rst ov8", ov8, 1'b0);
      chk("rst r8", r8, 8'd0);
      chk("rst cc8", cc8, 3'b100);
      chk("rst ir8", ir8, 1'b1);
      $display("reset v=%0b rdy=%0b -> ov64=%0b cc64=%b ov8=%0b cc8=%b", v, rdy, ov64, cc64, ov8, cc8);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; sc_s[k] = 1'b0; op_s[k] = 2'd0;
         a_s[k] = 64'd0; b_s[k] = 64'd0; n_in[k] = 0; n_out[k] = 0;
      end
      do_reset(1'b0, 1'b0);

      // Directed vectors on the 64-bit unit
      cyc(0, 1, 2'd3, 64'h31, 64'h26, 1, 1);
      chk("xor result", r64, 64'h17);
      chk("xor cc", cc64, 3'b000);
      cyc(0, 1, 2'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1, 1);
      chk("add ovf result", r64, 64'h8000_0000_0000_0000);
      chk("add ovf cc", cc64, 3'b011);
      cyc(0, 1, 2'd1, 64'd5, 64'd5, 1, 1);
      chk("sub zero result", r64, 64'd0);
      chk("sub zero cc", cc64, 3'b100);
      cyc(0, 0, 2'd0, 64'hFFFF, 64'h1, 1, 1);
      cyc(0, 0, 2'd1, 64'h1, 64'h8000_0000_0000_0000, 1, 1);
      chk("idle keeps cc", cc64, 3'b100);

      // Directed vectors on the 8-bit unit
      cyc(1, 1, 2'd1, 64'h01, 64'h80, 1, 1);
      chk("w8 sub result", r8, 8'h7F);
      chk("w8 sub cc", cc8, 3'b001);
      cyc(1, 1, 2'd2, 64'hF0, 64'h0F, 0, 1);
      chk("w8 and result", r8, 8'h00);
      chk("w8 and cc held", cc8, 3'b001);
      cyc(1, 0, 2'd0, 64'd0, 64'd0, 0, 1);

      // Back-pressure: stall three cycles with new ops offered, then stream
      cyc(0, 1, 2'd0, 64'd10, 64'd20, 1, 0);
      for (int k = 0; k < 3; k++)
         cyc(0, 1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1, 0);
      chk("stall r64", r64, 64'd30);
      for (int k = 0; k < 4; k++)
         cyc(0, 1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1);
      cyc(0, 0, 2'd0, 64'd0, 64'd0, 0, 1);
      chk("bp drained", n_out[0], n_in[0]);

      // Back-to-back stream of 16 random ops
      begin
         int base_in;
         int base_out;
         base_in  = n_in[0];
         base_out = n_out[0];
         for (int k = 0; k < 16; k++)
            cyc(0, 1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1);
         cyc(0, 0, 2'd0, 64'd0, 64'd0, 0, 1);
         chk("stream accepted", n_in[0] - base_in, 16);
         chk("stream delivered", n_out[0] - base_out, 16);
      end

      // Random handshake traffic on the 8-bit unit
      for (int k = 0; k < 40; k++)
         cyc(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset while a result is held and a new op is offered
      cyc(0, 1, 2'd0, 64'd7, 64'd9, 1, 0);
      chk("pre-rst ov64", ov64, 1'b1);
      do_reset(1'b1, 1'b1);
      cyc(0, 1, 2'd3, 64'hFF, 64'h0F, 1, 1);
      cyc(0, 0, 2'd0, 64'd0, 64'd0, 0, 1);
      chk("end queue u0", exq0.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_cc_unit.md
ALU_CC_UNIT -- requirements
Module: alu_cc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal: 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation presented.
REQ-005 SHALL have port in_ready  output  1  unit accepts operation this cycle.
REQ-006 SHALL have port op  input  2  function: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-007 SHALL have port a  input  WIDTH  operand A (valA).
REQ-008 SHALL have port b  input  WIDTH  operand B (valB).
REQ-009 SHALL have port set_cc  input  1  update condition codes with this operation.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port cc  output  3  registered {ZF, SF, OF}.

Function
REQ-014 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational; one-entry output register, full throughput).
REQ-016 Latency SHALL be 1 cycle: an operation accepted at edge N presents result with out_valid=1 after edge N.
REQ-017 ADD: result = b + a; SUB: result = b - a; AND: result = b & a; XOR: result = b ^ a; all modulo 2^WIDTH, carry-out discarded.
REQ-018 ZF = (result == 0); SF = result[WIDTH-1].
REQ-019 OF for ADD = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]); for SUB = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]); for AND/XOR = 0.
REQ-020 cc SHALL update on the same edge as transfer-in, only when set_cc=1; otherwise cc holds.
REQ-021 With out_valid=1 and out_ready=0: result, out_valid and cc SHALL hold; in_ready=0; inputs ignored.
REQ-022 Simultaneous transfer-out and transfer-in: new result loaded, out_valid stays 1, no bubble.
REQ-023 Transfer-out with no transfer-in: out_valid SHALL drop to 0; result holds last value.
REQ-024 op, a, b, set_cc SHALL be ignored when in_valid=0.

Reset
REQ-025 While rst=1 at a rising edge: out_valid=0, result=0, cc=3'b100 (ZF=1, SF=0, OF=0).
REQ-026 rst SHALL override any transfer in the same cycle; an in-flight result is discarded, not delivered.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-028 Shared package alu_pkg SHALL hold op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR) and cc bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
REQ-029 A combinational sub-module alu_core (parametrised WIDTH; op, a, b -> result, zf, sf, of) SHALL compute REQ-017..019; alu_cc_unit holds handshake and registers.

Verification
REQ-030 WIDTH=64, XOR a=0x31, b=0x26, set_cc=1 -> next cycle result=0x17, cc=3'b000.
REQ-031 WIDTH=64, ADD a=b=0x4000_0000_0000_0000, set_cc=1 -> result=0x8000_0000_0000_0000, cc=3'b011; then SUB a=5, b=5 -> result=0, cc=3'b100.
REQ-032 WIDTH=8, SUB a=0x01, b=0x80, set_cc=1 -> result=0x7F, cc=3'b001; AND a=0xF0, b=0x0F set_cc=0 -> result=0x00, cc stays 3'b001.
REQ-033 Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result/cc frozen; release -> one result per cycle, none lost or duplicated.
REQ-034 Back-to-back stream of 16 random ops with out_ready=1 -> 16 results, in order, matching a reference model, cc matching last set_cc op.
REQ-035 rst=1 asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, result=0, cc=3'b100, in_ready=1.
